// File: rtl/lfsr3_pkg.sv
// Shared types, constants and the 3-bit LFSR next-state function for lfsr3_checker.
package lfsr3_pkg;

  localparam int unsigned WORD_W = 3;
  localparam int unsigned RUN_W  = 3;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [WORD_W-1:0] LFSR3_ZERO = 3'b000;

  // N(s) = {s2^s1, s0, s2}: period 7 over the non-zero states
  function automatic logic [WORD_W-1:0] lfsr3_next(input logic [WORD_W-1:0] s);
    return {s[2] ^ s[1], s[0], s[2]};
  endfunction

endpackage

// File: rtl/lfsr3_checker.sv
// Locks onto a received 3-bit LFSR sequence, then flywheels and counts word errors.
// Optional macro LFSR3_CHK_ZERO_DET_EN enables the sticky all-zero-word flag.
module lfsr3_checker
  import lfsr3_pkg::*;
#(
  parameter int unsigned LOCK_N = 3,
  parameter int unsigned LOSS_N = 2,
  parameter int unsigned ERR_W  = 8
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_word,
  input  logic              clr_cnt,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              zero_stuck
);

  localparam logic [ERR_W-1:0] CNT_MAX = {ERR_W{1'b1}};

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  pred_q, pred_d;
  logic               have_seed_q, have_seed_d;
  logic [RUN_W-1:0]   match_run_q, match_run_d;
  logic [RUN_W-1:0]   miss_run_q, miss_run_d;
  logic               err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               count_err;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= HUNT;
      pred_q      <= LFSR3_ZERO;
      have_seed_q <= 1'b0;
      match_run_q <= '0;
      miss_run_q  <= '0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      have_seed_q <= have_seed_d;
      match_run_q <= match_run_d;
      miss_run_q  <= miss_run_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    have_seed_d = have_seed_q;
    match_run_d = match_run_q;
    miss_run_d  = miss_run_q;
    count_err   = 1'b0;

    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (in_word == LFSR3_ZERO) begin
            have_seed_d = 1'b0;
            match_run_d = '0;
          end else if (have_seed_q && (in_word == pred_q)) begin
            match_run_d = match_run_q + RUN_W'(1);
            pred_d      = lfsr3_next(in_word);
            if (match_run_d == RUN_W'(LOCK_N)) begin
              state_d    = LOCKED;
              miss_run_d = '0;
            end
          end else begin
            // first seed or reseed after a break in the sequence
            pred_d      = lfsr3_next(in_word);
            have_seed_d = 1'b1;
            match_run_d = '0;
          end
        end
        LOCKED: begin
          // flywheel: prediction advances from itself so one bad word costs one error
          pred_d = lfsr3_next(pred_q);
          if (in_word != pred_q) begin
            count_err  = 1'b1;
            miss_run_d = miss_run_q + RUN_W'(1);
            if (miss_run_d == RUN_W'(LOSS_N)) begin
              state_d     = HUNT;
              have_seed_d = 1'b0;
              match_run_d = '0;
              miss_run_d  = '0;
            end
          end else begin
            miss_run_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    err_pulse_d = count_err;

    err_cnt_d = err_cnt_q;
    if (clr_cnt) begin
      err_cnt_d = '0;
    end else if (count_err && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

`ifdef LFSR3_CHK_ZERO_DET_EN
  logic zero_stuck_q, zero_stuck_d;

  always_comb begin
    zero_stuck_d = zero_stuck_q;
    if (in_valid && (in_word == LFSR3_ZERO)) begin
      zero_stuck_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      zero_stuck_q <= 1'b0;
    end else begin
      zero_stuck_q <= zero_stuck_d;
    end
  end

  assign zero_stuck = zero_stuck_q;
`else
  assign zero_stuck = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr3_checker.sv
// Scoreboard bench for lfsr3_checker: driver pushes model expectations, monitor pops and compares.
module tb_lfsr3_checker;

  localparam int unsigned LOCK_N = 3;
  localparam int unsigned LOSS_N = 2;
  localparam int unsigned ERR_W  = 2;
  localparam int          CMAX   = (1 << ERR_W) - 1;

  typedef struct {
    logic             locked;
    logic             pulse;
    logic [ERR_W-1:0] cnt;
    logic             zero;
  } exp_t;

  logic             clk = 1'b0;
  logic             arst;
  logic             in_valid;
  logic [2:0]       in_word;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_cnt;
  logic             zero_stuck;

  lfsr3_checker #(.LOCK_N(LOCK_N), .LOSS_N(LOSS_N), .ERR_W(ERR_W)) dut (
    .clk        (clk),
    .arst       (arst),
    .in_valid   (in_valid),
    .in_word    (in_word),
    .clr_cnt    (clr_cnt),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_cnt    (err_cnt),
    .zero_stuck (zero_stuck)
  );

  always #5 clk = ~clk;

  // the LFSR cycle written out as a table; position in it is the model's notion of phase
  logic [2:0] seq [7] = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd7, 3'd3, 3'd6};

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  bit m_locked, m_have, m_zero, m_pulse;
  int m_last, m_run, m_phase, m_miss, m_cnt;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [2:0] w);
    for (int i = 0; i < 7; i++) if (seq[i] == w) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    m_locked = 0; m_have = 0; m_zero = 0; m_pulse = 0;
    m_last = 0; m_run = 0; m_phase = 0; m_miss = 0; m_cnt = 0;
  endfunction

  function automatic void model_step(input bit v, input logic [2:0] w, input bit c);
    int p;
    bit err;
    err = 0;
    if (v) begin
      p = idx_of(w);
      if (!m_locked) begin
        if (p < 0) begin
          m_have = 0; m_run = 0;
        end else if (m_have && p == (m_last + 1) % 7) begin
          m_run++; m_last = p;
          if (m_run == LOCK_N) begin m_locked = 1; m_phase = p; m_miss = 0; end
        end else begin
          m_have = 1; m_last = p; m_run = 0;
        end
      end else begin
        m_phase = (m_phase + 1) % 7;
        if (w != seq[m_phase]) begin
          err = 1; m_miss++;
          if (m_miss == LOSS_N) begin m_locked = 0; m_have = 0; m_run = 0; m_miss = 0; end
        end else begin
          m_miss = 0;
        end
      end
`ifdef LFSR3_CHK_ZERO_DET_EN
      if (w == 3'd0) m_zero = 1;
`endif
    end
    m_pulse = err;
    if (c) m_cnt = 0;
    else if (err && m_cnt < CMAX) m_cnt++;
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    e.locked = m_locked; e.pulse = m_pulse; e.cnt = ERR_W'(m_cnt); e.zero = m_zero;
    return e;
  endfunction

  function automatic logic [2:0] good_w();
    return seq[(m_phase + 1) % 7];
  endfunction

  function automatic logic [2:0] bad_w();
    return seq[(m_phase + 2) % 7];
  endfunction

  task automatic drive(input bit v, input logic [2:0] w, input bit c);
    @(negedge clk);
    arst = 1'b0; in_valid = v; in_word = w; clr_cnt = c;
    model_step(v, w, c);
    q.push_back(model_exp());
  endtask

  // asynchronous reset: outputs must clear before any clock edge arrives
  task automatic reset_pulse(input int n);
    @(negedge clk);
    arst = 1'b1; in_valid = 1'b0; clr_cnt = 1'b0;
    #1;
    chk("async_rst_locked", int'(locked), 0);
    chk("async_rst_cnt", int'(err_cnt), 0);
    chk("async_rst_pulse", int'(err_pulse), 0);
    chk("async_rst_zero", int'(zero_stuck), 0);
    model_reset();
    q.push_back(model_exp());
    repeat (n - 1) begin
      @(negedge clk);
      q.push_back(model_exp());
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("locked", int'(locked), int'(e.locked));
        chk("err_pulse", int'(err_pulse), int'(e.pulse));
        chk("err_cnt", int'(err_cnt), int'(e.cnt));
        chk("zero_stuck", int'(zero_stuck), int'(e.zero));
      end
    end
  end

  initial begin : stimulus
    int tx;
    bit v;
    logic [2:0] w;
    arst = 1'b1; in_valid = 1'b0; in_word = 3'd0; clr_cnt = 1'b0;
    model_reset();
    reset_pulse(3);

    // lock acquisition from a clean start
    drive(1, 3'd1, 0); drive(1, 3'd2, 0); drive(1, 3'd4, 0); drive(1, 3'd5, 0);
    // single corrupted word while locked
    drive(1, 3'd7, 0); drive(1, 3'd2, 0); drive(1, 3'd6, 0);
    // clear, then two consecutive bad words drop lock, then relock
    drive(0, 3'd0, 1);
    drive(1, bad_w(), 0); drive(1, bad_w(), 0);
    drive(1, 3'd1, 0); drive(1, 3'd2, 0); drive(1, 3'd4, 0); drive(1, 3'd5, 0);
    // saturation, then clear coincident with an error
    drive(0, 3'd0, 1);
    for (int i = 0; i < 5; i++) begin
      drive(1, bad_w(), 0);
      drive(1, good_w(), 0);
    end
    drive(1, bad_w(), 1);
    drive(1, good_w(), 0);
    // long in_valid gaps between correct words
    for (int i = 0; i < 4; i++) begin
      drive(1, good_w(), 0);
      repeat (10) drive(0, 3'($urandom_range(0, 7)), 0);
    end
    // reset while locked
    reset_pulse(2);
    drive(1, 3'd7, 0); drive(1, 3'd3, 0); drive(1, 3'd6, 0); drive(1, 3'd1, 0);
    // all-zero word while locked, then in hunt
    drive(1, 3'd0, 0); drive(1, good_w(), 0);
    drive(1, 3'd0, 0); drive(1, 3'd0, 0);
    drive(1, 3'd4, 0); drive(1, 3'd0, 0); drive(1, 3'd5, 0);

    // randomized traffic: mostly a clean sequence with corruptions, gaps and clears
    tx = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_pulse(2);
      end else begin
        v = ($urandom_range(0, 3) != 0);
        w = ($urandom_range(0, 99) < 85) ? seq[tx] : 3'($urandom_range(0, 7));
        if (v) tx = (tx + 1) % 7;
        if ($urandom_range(0, 29) == 0) tx = $urandom_range(0, 6);
        drive(v, w, ($urandom_range(0, 49) == 0));
      end
    end

    @(negedge clk);
    in_valid = 1'b0; clr_cnt = 1'b0;
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
